// File: rtl/phys_free_list.sv
// phys_free_list: circular FIFO of free physical register tags for rename.
// Ports: clk; reset (async, active-low); stall; alloc_req;
//   alloc_tag/alloc_valid (head of list); rel1/rel2 valid+tag (retire releases);
//   free_count, empty, full; err (sticky double-release flag).
// Optional macro FREELIST_CHECK_EN adds a free bitmap that drops and flags
// releases of tags that are already free; without it err is tied 0.
module phys_free_list #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32,
    parameter int TAG_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             alloc_req,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             alloc_valid,
    input  logic             rel1_valid,
    input  logic [TAG_W-1:0] rel1_tag,
    input  logic             rel2_valid,
    input  logic [TAG_W-1:0] rel2_tag,
    output logic [TAG_W:0]   free_count,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam logic [TAG_W:0]   CNT_MAX  = (TAG_W+1)'(NUM_PHYS);
    localparam logic [TAG_W:0]   CNT_RST  = (TAG_W+1)'(NUM_PHYS - NUM_ARCH);
    localparam logic [TAG_W-1:0] TAIL_RST = TAG_W'(NUM_PHYS - NUM_ARCH);

    logic [TAG_W-1:0] fifo_q [NUM_PHYS];
    logic [TAG_W-1:0] fifo_d [NUM_PHYS];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic             alloc_fire;
    logic             bad1, bad2;
    logic             acc1, acc2;
    logic [TAG_W:0]   count_rel1;
    logic [TAG_W-1:0] slot2;

    assign alloc_valid = (count_q != '0);
    assign alloc_tag   = fifo_q[head_q];
    assign free_count  = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_MAX);
    assign alloc_fire  = alloc_req && alloc_valid && !stall;

`ifdef FREELIST_CHECK_EN
    logic [NUM_PHYS-1:0] map_q, map_d, map_eff;
    logic                err_q, err_d;

    // The tag leaving the head this cycle counts as no longer free, so
    // releasing it in the same cycle is legal.
    always_comb begin
        map_eff = map_q;
        if (alloc_fire) map_eff[alloc_tag] = 1'b0;
        bad1 = rel1_valid && map_eff[rel1_tag];
        bad2 = rel2_valid &&
               (map_eff[rel2_tag] || (rel1_valid && rel1_tag == rel2_tag));
    end

    always_comb begin
        map_d = map_eff;
        if (acc1) map_d[rel1_tag] = 1'b1;
        if (acc2) map_d[rel2_tag] = 1'b1;
        err_d = err_q | bad1 | bad2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PHYS; i++)
                map_q[i] <= (i >= NUM_ARCH);
            err_q <= 1'b0;
        end else begin
            map_q <= map_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign bad1 = 1'b0;
    assign bad2 = 1'b0;
    assign err  = 1'b0;
`endif

    // rel2 sees the count already including an accepted rel1.
    always_comb begin
        acc1       = rel1_valid && !bad1 && (count_q < CNT_MAX);
        count_rel1 = count_q + (TAG_W+1)'(acc1);
        acc2       = rel2_valid && !bad2 && (count_rel1 < CNT_MAX);
        slot2      = acc1 ? tail_q + TAG_W'(1) : tail_q;
    end

    always_comb begin
        fifo_d = fifo_q;
        if (acc1) fifo_d[tail_q] = rel1_tag;
        if (acc2) fifo_d[slot2]  = rel2_tag;
        head_d  = head_q + TAG_W'(alloc_fire);
        tail_d  = tail_q + TAG_W'(acc1) + TAG_W'(acc2);
        count_d = count_rel1 + (TAG_W+1)'(acc2)
                  - (TAG_W+1)'(alloc_fire);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PHYS; i++)
                fifo_q[i] <= (i < NUM_PHYS - NUM_ARCH) ?
                             TAG_W'(NUM_ARCH + i) : '0;
            head_q  <= '0;
            tail_q  <= TAIL_RST;
            count_q <= CNT_RST;
        end else begin
            fifo_q  <= fifo_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
